// File: rtl/msg_ser_loader.sv
// msg_ser_loader: collects a byte message, translates each byte to a 7-bit
// display code and streams exactly WORD_COUNT words to the serial text ring.
// Optional build macro: LOWERCASE_FOLD_EN (fold 0x60..0x7F to uppercase glyphs).
module msg_ser_loader #(
  parameter int unsigned WORD_COUNT = 28,
  parameter logic [6:0]  PAD_CODE   = 7'h40
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_last,
  output logic       ser_write,
  output logic       ser_din,
  output logic       disp_reset,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(WORD_COUNT + 1);
  localparam int unsigned IDX_W = $clog2(WORD_COUNT);

  typedef enum logic [1:0] {COLLECT, SYNC, SEND} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   w_q, w_d;
  logic [2:0]         ph_q, ph_d;
  logic [6:0]         mem_q [WORD_COUNT];
  logic               wr_en;
  logic               accept;
  logic [6:0]         code;
  logic [6:0]         word_sel;
  logic [7:0]         frame_byte;

  logic in_ready_q, in_ready_d;
  logic ser_write_q, ser_write_d;
  logic ser_din_q, ser_din_d;
  logic disp_reset_q, disp_reset_d;
  logic busy_q, busy_d;

  assign accept = in_valid && in_ready_q;

  // Byte to display-code translation, applied at accept time
  always_comb begin
    code = PAD_CODE;
    if (in_data[7]) begin
      code = {1'b0, in_data[5:0]};
    end else if (in_data >= 8'h20 && in_data < 8'h60) begin
      code = {1'b1, 6'(in_data - 8'h20)};
    end else if (in_data >= 8'h60) begin
`ifdef LOWERCASE_FOLD_EN
      code = {1'b1, 6'(in_data - 8'h40)};
`else
      code = PAD_CODE;
`endif
    end
  end

  // Next-state logic: collect, one-cycle phase sync, then a full ring pass
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    ph_d    = ph_q;
    wr_en   = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (accept) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (in_last || cnt_q == CNT_W'(WORD_COUNT - 1)) begin
            state_d = SYNC;
          end
        end
      end
      SYNC: begin
        state_d = SEND;
        w_d     = '0;
        ph_d    = '0;
      end
      SEND: begin
        ph_d = ph_q + 3'd1;
        if (ph_q == 3'd7) begin
          if (w_q == IDX_W'(WORD_COUNT - 1)) begin
            state_d = COLLECT;
            cnt_d   = '0;
            w_d     = '0;
          end else begin
            w_d = w_q + IDX_W'(1);
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // Output decode from next state so every output leaves a flop
  always_comb begin
    word_sel     = (CNT_W'(w_d) < cnt_d) ? mem_q[w_d] : PAD_CODE;
    frame_byte   = {1'b0, word_sel};
    in_ready_d   = (state_d == COLLECT);
    disp_reset_d = (state_d == SYNC);
    ser_write_d  = (state_d == SEND);
    busy_d       = (state_d != COLLECT);
    ser_din_d    = ser_write_d && frame_byte[ph_d];
  end

  // State, counters and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= COLLECT;
      cnt_q        <= '0;
      w_q          <= '0;
      ph_q         <= '0;
      in_ready_q   <= 1'b1;
      ser_write_q  <= 1'b0;
      ser_din_q    <= 1'b0;
      disp_reset_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      w_q          <= w_d;
      ph_q         <= ph_d;
      in_ready_q   <= in_ready_d;
      ser_write_q  <= ser_write_d;
      ser_din_q    <= ser_din_d;
      disp_reset_q <= disp_reset_d;
      busy_q       <= busy_d;
    end
  end

  // Message store holds translated codes; cleared on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(WORD_COUNT); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[IDX_W'(cnt_q)] <= code;
    end
  end

  assign in_ready   = in_ready_q;
  assign ser_write  = ser_write_q;
  assign ser_din    = ser_din_q;
  assign disp_reset = disp_reset_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_msg_ser_loader.sv
// Directed testbench for msg_ser_loader.
module tb_msg_ser_loader;

  localparam int WC = 28;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       in_last;
  logic       ser_write;
  logic       ser_din;
  logic       disp_reset;
  logic       busy;

  int checks;
  int errors;
  logic [6:0] exp_codes [WC];

  msg_ser_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .ser_write  (ser_write),
    .ser_din    (ser_din),
    .disp_reset (disp_reset),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic fill_exp();
    for (int i = 0; i < WC; i++) exp_codes[i] = 7'h40;
  endtask

  // Present one byte from a negedge; returns at the negedge after acceptance
  task automatic send_byte(input logic [7:0] d, input logic last);
    bit ok;
    ok = 0;
    in_data = d; in_valid = 1'b1; in_last = last;
    for (int t = 0; t < 1000 && !ok; t++) begin
      if (in_ready === 1'b1) ok = 1;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout byte=%h got no in_ready want in_ready=1", d);
    end
  endtask

  // Entered at the negedge of the SYNC cycle; checks the full ring pass
  task automatic run_message(input string name);
    logic [7:0] frame;
    int bad;
    bad = 0;
    checks++;
    if (disp_reset !== 1'b1 || ser_write !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_sync got dr=%b wr=%b rdy=%b busy=%b want 1 0 0 1",
               name, disp_reset, ser_write, in_ready, busy);
    end
    for (int f = 0; f < WC; f++) begin
      frame = 8'h00;
      for (int p = 0; p < 8; p++) begin
        @(negedge clk);
        frame[p] = ser_din;
        if (ser_write !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || disp_reset !== 1'b0) bad++;
      end
      checks++;
      if (frame !== {1'b0, exp_codes[f]}) begin
        errors++;
        $display("FAIL %s_frame%0d got %h want %h", name, f, frame, {1'b0, exp_codes[f]});
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_send_ctrl got %0d bad cycles want 0", name, bad);
    end
    @(negedge clk);
    checks++;
    if (ser_write !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || disp_reset !== 1'b0) begin
      errors++;
      $display("FAIL %s_end got wr=%b rdy=%b busy=%b dr=%b want 0 1 0 0",
               name, ser_write, in_ready, busy, disp_reset);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || ser_write !== 1'b0 || ser_din !== 1'b0 ||
        disp_reset !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals got rdy=%b wr=%b din=%b dr=%b busy=%b want 1 0 0 0 0",
               in_ready, ser_write, ser_din, disp_reset, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_hi();
    fill_exp();
    exp_codes[0] = 7'h68;
    exp_codes[1] = 7'h69;
    send_byte(8'h48, 1'b0);
    send_byte(8'h49, 1'b1);
    run_message("hi");
  endtask

  task automatic test_raw();
    fill_exp();
    exp_codes[0] = 7'h05;
    send_byte(8'h85, 1'b1);
    run_message("raw");
  endtask

  task automatic test_lower_ctrl();
    fill_exp();
`ifdef LOWERCASE_FOLD_EN
    exp_codes[0] = 7'h61;
`else
    exp_codes[0] = 7'h40;
`endif
    send_byte(8'h61, 1'b1);
    run_message("lower");
    fill_exp();
    send_byte(8'h0A, 1'b1);
    run_message("ctrl");
  endtask

  task automatic test_truncate();
    int acc;
    int acc2;
    fill_exp();
    for (int i = 0; i < WC; i++) exp_codes[i] = 7'h61;
    acc = 0;
    in_data = 8'h41; in_last = 1'b0; in_valid = 1'b1;
    for (int t = 0; t < 100 && acc < WC; t++) begin
      if (in_ready === 1'b1) acc++;
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (acc != WC) begin
      errors++;
      $display("FAIL trunc_accepts got %0d want %0d", acc, WC);
    end
    run_message("trunc");
    acc2 = 0;
    for (int t = 0; t < 10 && acc2 < 2; t++) begin
      if (in_ready === 1'b1) acc2++;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (acc2 != 2) begin
      errors++;
      $display("FAIL trunc_held_bytes got %0d want 2", acc2);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL trunc_after got rdy=%b busy=%b want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_reset_mid_send();
    int bad;
    send_byte(8'h48, 1'b1);
    checks++;
    if (disp_reset !== 1'b1) begin
      errors++;
      $display("FAIL midrst_sync got dr=%b want 1", disp_reset);
    end
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || ser_write !== 1'b0 || ser_din !== 1'b0 ||
        disp_reset !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_vals got rdy=%b wr=%b din=%b dr=%b busy=%b want 1 0 0 0 0",
               in_ready, ser_write, ser_din, disp_reset, busy);
    end
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (ser_write !== 1'b0 || busy !== 1'b0) bad++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (ser_write !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midrst_quiet got %0d bad cycles want 0", bad);
    end
    fill_exp();
    exp_codes[0] = 7'h05;
    send_byte(8'h85, 1'b1);
    run_message("postrst");
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0;
    in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0;
    checks = 0; errors = 0;
    @(negedge clk);
    test_reset();
    test_hi();
    test_raw();
    test_lower_ctrl();
    test_truncate();
    test_reset_mid_send();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
